pipe_stage_chain: RTL and testbench
===================================

Name: pipe_stage_chain

Overview:
- Parametrised chain of pipeline registers with per-stage valid bits, stall propagation, bubble insertion and branch/jump flush.
- Replaces the hand-instanced fixed inter-stage registers (fetch/decode, decode/execute, execute/memory, memory/writeback) with one generic block.
- Payload is an opaque bus: control plus data fields packed by the instantiating top level.
- Stage 0 is the youngest stage (fetch side); stage STAGES-1 is the oldest stage (writeback side).

Parameters:
- WIDTH, 32, payload bits per stage.
- STAGES, 4, number of register stages (>=2).
- FLUSH_STAGES, 2, number of youngest stages killed by flush (1..STAGES).

Ports:
- Clk  input  1  clock, rising edge.
- Rst  input  1  asynchronous active-low reset.
- in_valid  input  1  producer presents an instruction/payload.
- in_data  input  WIDTH  payload into stage 0.
- in_ready  output  1  stage 0 accepts this cycle.
- stall_req  input  STAGES  bit i = stage i must hold (hazard, multi-cycle op).
- flush  input  1  kill the FLUSH_STAGES youngest stages (taken branch/jump resolved).
- stage_valid  output  STAGES  valid bit of every stage.
- stage_data  output  STAGES*WIDTH  flattened payload; stage i at [i*WIDTH +: WIDTH].
- out_valid  output  1  equals stage_valid[STAGES-1].
- out_data  output  WIDTH  payload of stage STAGES-1.

Behaviour:
- Reset (Rst=0, asynchronous): every valid bit is 0 and every data register is 0. This holds immediately and persists until the first rising edge after Rst returns to 1.
- Hold term: hold[i] = OR of stall_req[i..STAGES-1]. An older stall freezes every younger stage.
- Stage update per rising edge, highest priority first:
  1. Flush: if flush=1 and i<FLUSH_STAGES, valid[i] is 0 and data[i] is unchanged. Flush overrides hold.
  2. Hold: if hold[i]=1, valid[i] and data[i] are retained.
  3. Stage 0 load: if i=0, valid[0] takes in_valid and data[0] takes in_data.
  4. Bubble: if i>0 and hold[i-1]=1, valid[i] is 0 and data[i] is unchanged.
  5. Advance: otherwise stage i takes valid[i-1] and data[i-1].
- Latency: 1 cycle per stage. An unstalled payload reaches out_data STAGES cycles after acceptance.
- in_ready = !hold[0]. It is combinational and ignores flush.
- Input handshake: a payload is transferred when in_valid && in_ready at a rising edge. If in_valid && !in_ready, the producer holds in_data stable.
- A payload accepted in a flush cycle is discarded, because stage 0 is always within the flush range.
- Output: there is no backpressure. The consumer samples out_data every cycle that out_valid=1. stall_req[STAGES-1]=1 holds the output stage and therefore presents the same payload again; the consumer must account for this.
- An invalid stage still shifts its data. Consumers must gate on stage_valid.
- Stall and flush on the same edge: the flushed stages clear, and the other held stages retain.
- Reset mid-operation: all in-flight payloads are lost with no drain.
- No combinational path exists from stall_req or flush to stage_data. The only combinational path from stall_req is to in_ready.

Optional Feature:
- Macro: PIPE_STAGE_CHAIN_PERF_EN.
- When defined, adds three 32-bit outputs: perf_stall_cnt, perf_bubble_cnt and perf_flush_cnt.
- perf_stall_cnt increments each cycle hold[0]=1.
- perf_bubble_cnt increments each cycle any bubble is inserted by rule 4.
- perf_flush_cnt increments each cycle flush=1 and at least one flushed stage was valid.
- All three counters wrap at 2^32 and reset to 0 with Rst.
- When not defined, the ports and logic are absent and the remaining behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds the default WIDTH/STAGES constants and the index helper for the stage_data slice.
- pipe_pkg also holds the packed payload field offsets used by the CPU top level: RegWrite, MemToReg, RegDst, PC4, ALUResult and the other stage control/data fields.
- One natural sub-module is pipe_stage_reg: a single valid+data register with load, hold, bubble and kill controls, generated STAGES times. The hold/bubble decode lives in the parent.

Test Plan:
- Free flow: STAGES=4, WIDTH=32. Push 0x11, 0x22, 0x33, 0x44 on consecutive cycles with stall_req=0. Required: out_data shows 0x11 at cycle 4 through 0x44 at cycle 7, with out_valid=1 throughout.
- Load-use stall: fill the chain with A..D, then pulse stall_req=4'b0010 for 1 cycle. Required: stages 0–1 hold, stage 2 becomes a bubble (valid 0), stage 3 advances, and in_ready=0 during the stall.
- Flush: FLUSH_STAGES=2 with a full chain, then assert flush with in_valid=1 and in_data=0x55. Required: stage_valid becomes 4'b1100, and 0x55 is never seen at the output.
- Flush with stall: assert stall_req=4'b1000 and flush together. Required: stages 0–1 clear, stages 2–3 retain, and out_data repeats for 1 cycle.
- Async reset: drive Rst=0 mid-cycle with a full chain. Required: stage_valid=0 and stage_data=0 immediately, without waiting for a clock edge. After release, the first accepted payload appears at the output 4 cycles later.
- PERF: with PIPE_STAGE_CHAIN_PERF_EN defined, apply 3 stall cycles, 2 bubbles and 1 effective flush. Required: the counters read 3, 2 and 1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline constants: default geometry, per-stage action encoding,
// stage_data slice helper and the CPU payload field layout.
package pipe_pkg;

    localparam int DefaultWidth  = 32;
    localparam int DefaultStages = 4;

    typedef enum logic [2:0] {
        ActAdvance = 3'd0,
        ActLoad    = 3'd1,
        ActHold    = 3'd2,
        ActBubble  = 3'd3,
        ActKill    = 3'd4
    } stageAct_e;

    // Lowest bit of stage `stage` inside the flattened stage_data bus.
    function automatic int stageLsb(input int stage, input int width);
        return stage * width;
    endfunction

    // Control field bits, packed at the bottom of every CPU inter-stage payload.
    localparam int CtrlRegWrite   = 0;
    localparam int CtrlMemToReg   = 1;
    localparam int CtrlRegDst     = 2;
    localparam int CtrlMemRead    = 3;
    localparam int CtrlMemWrite   = 4;
    localparam int CtrlBranch     = 5;
    localparam int CtrlAluSrc     = 6;
    localparam int CtrlJump       = 7;
    localparam int CtrlAluOpLsb   = 8;
    localparam int CtrlAluOpWidth = 2;
    localparam int CtrlWidth      = CtrlAluOpLsb + CtrlAluOpWidth;

    localparam int WordWidth      = 32;
    localparam int RegAddrWidth   = 5;

    localparam int Pc4Lsb         = CtrlWidth;
    localparam int InstrLsb       = Pc4Lsb + WordWidth;
    localparam int ReadData1Lsb   = InstrLsb + WordWidth;
    localparam int ReadData2Lsb   = ReadData1Lsb + WordWidth;
    localparam int ImmLsb         = ReadData2Lsb + WordWidth;
    localparam int AluResultLsb   = ImmLsb + WordWidth;
    localparam int MemDataLsb     = AluResultLsb + WordWidth;
    localparam int WriteRegLsb    = MemDataLsb + WordWidth;
    localparam int CpuPayloadWidth = WriteRegLsb + RegAddrWidth;

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage: valid bit plus payload register, driven by a decoded
// action from the parent chain (advance/load, hold, bubble, kill).
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH = DefaultWidth
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [2:0]       act,
    input  logic             srcValid,
    input  logic [WIDTH-1:0] srcData,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Kill and bubble only drop the valid bit; the payload is left as is.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            case (act)
                ActKill, ActBubble: begin
                    valid <= 1'b0;
                end
                ActLoad, ActAdvance: begin
                    valid <= srcValid;
                    data  <= srcData;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_stage_chain.sv
// Generic pipeline register chain with stall, bubble and flush handling.
// Optional performance counters are built when PIPE_STAGE_CHAIN_PERF_EN is defined.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH        = DefaultWidth,
    parameter int STAGES       = DefaultStages,
    parameter int FLUSH_STAGES = 2
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    in_valid,
    input  logic [WIDTH-1:0]        in_data,
    output logic                    in_ready,
    input  logic [STAGES-1:0]       stall_req,
    input  logic                    flush,
    output logic [STAGES-1:0]       stage_valid,
    output logic [STAGES*WIDTH-1:0] stage_data,
`ifdef PIPE_STAGE_CHAIN_PERF_EN
    output logic [31:0]             perf_stall_cnt,
    output logic [31:0]             perf_bubble_cnt,
    output logic [31:0]             perf_flush_cnt,
`endif
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data
);

    logic [STAGES-1:0] hold;
`ifdef PIPE_STAGE_CHAIN_PERF_EN
    logic [STAGES-1:0] bubbleVec;
`endif

    for (genvar i = 0; i < STAGES; i++) begin : gStage
        localparam int Lsb = stageLsb(i, WIDTH);

        stageAct_e        act;
        logic             srcValid;
        logic [WIDTH-1:0] srcData;

        // An older stall freezes every younger stage.
        assign hold[i] = |(stall_req >> i);

        if (i == 0) begin : gHead
            assign srcValid = in_valid;
            assign srcData  = in_data;

            always_comb begin
                if (flush && (i < FLUSH_STAGES)) act = ActKill;
                else if (hold[i])                act = ActHold;
                else                             act = ActLoad;
            end
        end else begin : gBody
            assign srcValid = stage_valid[i-1];
            assign srcData  = stage_data[stageLsb(i-1, WIDTH) +: WIDTH];

            always_comb begin
                if (flush && (i < FLUSH_STAGES)) act = ActKill;
                else if (hold[i])                act = ActHold;
                else if (hold[i-1])              act = ActBubble;
                else                             act = ActAdvance;
            end
        end

`ifdef PIPE_STAGE_CHAIN_PERF_EN
        assign bubbleVec[i] = (act == ActBubble);
`endif

        pipe_stage_reg #(
            .WIDTH (WIDTH)
        ) uStageReg (
            .Clk      (Clk),
            .Rst      (Rst),
            .act      (act),
            .srcValid (srcValid),
            .srcData  (srcData),
            .valid    (stage_valid[i]),
            .data     (stage_data[Lsb +: WIDTH])
        );
    end

    // Flush is deliberately ignored: a payload taken in a flush cycle is simply killed.
    assign in_ready  = !hold[0];
    assign out_valid = stage_valid[STAGES-1];
    assign out_data  = stage_data[stageLsb(STAGES-1, WIDTH) +: WIDTH];

`ifdef PIPE_STAGE_CHAIN_PERF_EN
    logic flushedValid;

    always_comb begin
        flushedValid = 1'b0;
        for (int i = 0; i < FLUSH_STAGES; i++) begin
            flushedValid = flushedValid | stage_valid[i];
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            perf_stall_cnt  <= '0;
            perf_bubble_cnt <= '0;
            perf_flush_cnt  <= '0;
        end else begin
            if (hold[0])               perf_stall_cnt  <= perf_stall_cnt + 32'd1;
            if (|bubbleVec)            perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            if (flush && flushedValid) perf_flush_cnt  <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Randomised bench for pipe_stage_chain against a per-stage rule model,
// plus directed flow, load-use, flush, flush+stall, async reset and counter cases.
module tb_pipe_stage_chain;

    localparam int STAGES = 4;
    localparam int WIDTH  = 32;
    localparam int FLUSHN = 2;

    logic                    Clk;
    logic                    Rst;
    logic                    in_valid;
    logic [WIDTH-1:0]        in_data;
    logic                    in_ready;
    logic [STAGES-1:0]       stall_req;
    logic                    flush;
    logic [STAGES-1:0]       stage_valid;
    logic [STAGES*WIDTH-1:0] stage_data;
    logic                    out_valid;
    logic [WIDTH-1:0]        out_data;
`ifdef PIPE_STAGE_CHAIN_PERF_EN
    logic [31:0]             perf_stall_cnt;
    logic [31:0]             perf_bubble_cnt;
    logic [31:0]             perf_flush_cnt;
`endif

    int vecCnt  = 0;
    int missCnt = 0;

    logic [STAGES-1:0] mValid;
    logic [WIDTH-1:0]  mData [STAGES];
    logic [31:0]       mStall, mBubble, mFlush;

    pipe_stage_chain #(
        .WIDTH        (WIDTH),
        .STAGES       (STAGES),
        .FLUSH_STAGES (FLUSHN)
    ) dut (
        .Clk             (Clk),
        .Rst             (Rst),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_ready        (in_ready),
        .stall_req       (stall_req),
        .flush           (flush),
        .stage_valid     (stage_valid),
        .stage_data      (stage_data),
`ifdef PIPE_STAGE_CHAIN_PERF_EN
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_bubble_cnt (perf_bubble_cnt),
        .perf_flush_cnt  (perf_flush_cnt),
`endif
        .out_valid       (out_valid),
        .out_data        (out_data)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vecCnt++;
        if (got !== exp) begin
            missCnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] modelFlat();
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < STAGES; i++) r[i*WIDTH +: WIDTH] = mData[i];
        return r;
    endfunction

    task automatic modelReset();
        mValid  = '0;
        for (int i = 0; i < STAGES; i++) mData[i] = '0;
        mStall  = '0;
        mBubble = '0;
        mFlush  = '0;
    endtask

    // Next state from the stage update rules, evaluated on the pre-edge state.
    task automatic modelStep(input logic v, input logic [WIDTH-1:0] d,
                             input logic [STAGES-1:0] st, input logic fl);
        logic [STAGES-1:0] h;
        logic [STAGES-1:0] nV;
        logic [WIDTH-1:0]  nD [STAGES];
        logic              bubbled;
        logic              flushedValid;
        bubbled      = 1'b0;
        flushedValid = 1'b0;
        for (int i = 0; i < STAGES; i++) h[i] = ((st >> i) != '0);
        for (int i = 0; i < FLUSHN; i++) flushedValid = flushedValid | mValid[i];
        for (int i = 0; i < STAGES; i++) begin
            nV[i] = mValid[i];
            nD[i] = mData[i];
            if (fl && i < FLUSHN) nV[i] = 1'b0;
            else if (h[i]) begin end
            else if (i == 0) begin
                nV[i] = v;
                nD[i] = d;
            end else if (h[i-1]) begin
                nV[i]   = 1'b0;
                bubbled = 1'b1;
            end else begin
                nV[i] = mValid[i-1];
                nD[i] = mData[i-1];
            end
        end
        if (h[0])                mStall  = mStall + 32'd1;
        if (bubbled)             mBubble = mBubble + 32'd1;
        if (fl && flushedValid)  mFlush  = mFlush + 32'd1;
        mValid = nV;
        for (int i = 0; i < STAGES; i++) mData[i] = nD[i];
    endtask

    task automatic checkState();
        chk("stage_valid", 128'(stage_valid), 128'(mValid));
        chk("stage_data", stage_data, modelFlat());
        chk("out_valid", 128'(out_valid), 128'(mValid[STAGES-1]));
        chk("out_data", 128'(out_data), 128'(mData[STAGES-1]));
`ifdef PIPE_STAGE_CHAIN_PERF_EN
        chk("perf_stall", 128'(perf_stall_cnt), 128'(mStall));
        chk("perf_bubble", 128'(perf_bubble_cnt), 128'(mBubble));
        chk("perf_flush", 128'(perf_flush_cnt), 128'(mFlush));
`endif
    endtask

    // Called at posedge+1; returns at the next posedge+1 with the model advanced.
    task automatic cycle(input logic v, input logic [WIDTH-1:0] d,
                         input logic [STAGES-1:0] st, input logic fl);
        in_valid  = v;
        in_data   = d;
        stall_req = st;
        flush     = fl;
        #1;
        chk("in_ready", 128'(in_ready), 128'(st == '0));
        modelStep(v, d, st, fl);
        @(posedge Clk);
        #1;
        checkState();
    endtask

    task automatic fill(input logic [WIDTH-1:0] base);
        for (int k = 0; k < STAGES; k++) cycle(1'b1, base + WIDTH'(k), '0, 1'b0);
    endtask

    initial begin
        logic              seen55;
        logic              rv, rfl, prevV, prevReady;
        logic [WIDTH-1:0]  rd, prevD;
        logic [STAGES-1:0] rst4;

        Rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        stall_req = '0;
        flush     = 1'b0;
        modelReset();
        #2;
        checkState();
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        #10;
        Rst = 1'b1;

        // Free flow: 0x11..0x44 appear at the output on cycles 4..7.
        for (int c = 1; c <= 7; c++) begin
            cycle(c <= 4, (c <= 4) ? 32'(32'h11 * c) : '0, '0, 1'b0);
            if (c >= 4) begin
                chk("flow_out_data", 128'(out_data), 128'(32'h11 * (c - 3)));
                chk("flow_out_valid", 128'(out_valid), 128'(1));
            end
        end

        // Load-use stall on stage 1 with A..D in flight.
        fill(32'hA);
        cycle(1'b1, 32'hE, 4'b0010, 1'b0);
        chk("lu_in_ready", 128'(in_ready), 128'(0));
        chk("lu_valid", 128'(stage_valid), 128'(4'b1011));
        chk("lu_out_data", 128'(out_data), 128'(32'hB));
        chk("lu_stage1", 128'(stage_data[1*WIDTH +: WIDTH]), 128'(32'hC));
        chk("lu_stage0", 128'(stage_data[0 +: WIDTH]), 128'(32'hD));
        cycle(1'b0, '0, '0, 1'b0);

        // Flush with a payload offered in the same cycle.
        fill(32'h61);
        cycle(1'b1, 32'h55, '0, 1'b1);
        chk("flush_valid", 128'(stage_valid), 128'(4'b1100));
        seen55 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cycle(1'b0, '0, '0, 1'b0);
            if (out_valid && out_data == 32'h55) seen55 = 1'b1;
        end
        chk("flush_no_55", 128'(seen55), 128'(0));

        // Flush together with an output-stage stall.
        fill(32'h71);
        cycle(1'b1, 32'h99, 4'b1000, 1'b1);
        chk("fs_valid", 128'(stage_valid), 128'(4'b1100));
        chk("fs_out_repeat", 128'(out_data), 128'(32'h71));
        chk("fs_stage2", 128'(stage_data[2*WIDTH +: WIDTH]), 128'(32'h72));
        cycle(1'b0, '0, '0, 1'b0);
        chk("fs_out_next", 128'(out_data), 128'(32'h72));

        // Asynchronous reset mid-cycle with a full chain.
        fill(32'h81);
        #3;
        Rst = 1'b0;
        #1;
        modelReset();
        chk("arst_valid", 128'(stage_valid), 128'(0));
        chk("arst_data", stage_data, 128'(0));
        in_valid = 1'b0;
        in_data  = '0;
        #6;
        Rst = 1'b1;
        cycle(1'b1, 32'h77, '0, 1'b0);
        for (int k = 0; k < 3; k++) cycle(1'b0, '0, '0, 1'b0);
        chk("arst_first_out", 128'(out_data), 128'(32'h77));
        chk("arst_first_valid", 128'(out_valid), 128'(1));

        // 3 stall cycles, 2 bubbles, 1 effective flush since the reset above.
        fill(32'h91);
        cycle(1'b1, 32'hF0, 4'b1000, 1'b0);
        cycle(1'b1, 32'hF0, 4'b0010, 1'b0);
        cycle(1'b1, 32'hF0, 4'b0010, 1'b0);
        cycle(1'b1, 32'hF1, '0, 1'b1);
`ifdef PIPE_STAGE_CHAIN_PERF_EN
        chk("perf_stall_dir", 128'(perf_stall_cnt), 128'(3));
        chk("perf_bubble_dir", 128'(perf_bubble_cnt), 128'(2));
        chk("perf_flush_dir", 128'(perf_flush_cnt), 128'(1));
`endif

        // Random traffic; the producer keeps its payload while not accepted.
        prevV     = 1'b0;
        prevD     = '0;
        prevReady = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if (prevV && !prevReady) begin
                rv = prevV;
                rd = prevD;
            end else begin
                rv = ($urandom_range(0, 3) != 0);
                rd = $urandom;
            end
            if ($urandom_range(0, 3) == 0) rst4 = 4'($urandom_range(1, 15));
            else                           rst4 = '0;
            rfl = ($urandom_range(0, 7) == 0);
            cycle(rv, rd, rst4, rfl);
            prevV     = rv;
            prevD     = rd;
            prevReady = (rst4 == '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
        $finish;
    end

endmodule
